// File: rtl/ym_bus_pkg.sv
// ym_bus_pkg: shared state, request type and PSG bus widths for the ym2149 bus master
package ym_bus_pkg;
  localparam int YM_AW = 4;
  localparam int YM_DW = 8;
  typedef enum logic [2:0] {
    YM_IDLE, YM_ADDR_PH, YM_ADDR_GAP, YM_DATA_PH, YM_DATA_GAP, YM_RD_WAIT
  } ym_bus_state_t;
  typedef struct packed {
    logic             rd;
    logic [YM_AW-1:0] addr;
    logic [YM_DW-1:0] data;
  } ym_req_t;
endpackage

// File: rtl/ym_req_fifo.sv
// ym_req_fifo: synchronous request FIFO with occupancy count
module ym_req_fifo
  import ym_bus_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   push,
  input  logic                   pop,
  input  ym_req_t                din,
  output ym_req_t                dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  ym_req_t mem [DEPTH];
  logic [AW-1:0] wp, rp;
  assign dout  = mem[rp];
  assign full  = level == LW'(DEPTH);
  assign empty = level == '0;
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      wp    <= wp + AW'(push);
      rp    <= rp + AW'(pop);
      level <= level + LW'(push) - LW'(pop);
    end
  end
  always_ff @(posedge CLK) begin
    if (push) mem[wp] <= din;
  end
endmodule

// File: rtl/ym_bus_master.sv
// ym_bus_master: queues PSG register requests and drives registered BDIR/BC/A8/DO strobes.
// Define YM_ADDR_CACHE_EN to let writes to the last latched register skip the address phase.
module ym_bus_master
  import ym_bus_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int HOLD_CYCLES = 2,
  parameter int GAP_CYCLES  = 1
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        REQ_VALID,
  output logic                        REQ_READY,
  input  logic                        REQ_RD,
  input  logic [YM_AW-1:0]            REQ_ADDR,
  input  logic [YM_DW-1:0]            REQ_DATA,
  output logic                        BDIR,
  output logic                        BC,
  output logic                        A8,
  output logic [YM_DW-1:0]            DO,
  input  logic [YM_DW-1:0]            DI,
  output logic                        RD_VALID,
  output logic [YM_DW-1:0]            RD_DATA,
  output logic                        BUSY,
  output logic [$clog2(FIFO_DEPTH):0] LEVEL
);
  localparam int MAXC = HOLD_CYCLES > GAP_CYCLES ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW = $clog2(MAXC) + 1;
  localparam logic [CW-1:0] HLD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GP = CW'(GAP_CYCLES - 1);
  ym_bus_state_t state;
  ym_req_t req, head, din;
  logic [CW-1:0] cnt;
  logic empty, full, push, pop, hit;
  assign din       = {REQ_RD, REQ_ADDR, REQ_DATA};
  assign REQ_READY = !full;
  assign push      = REQ_VALID && !full;
  assign pop       = state == YM_IDLE && !empty;
  assign BUSY      = state != YM_IDLE || !empty;
  ym_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK(CLK), .RESET(RESET), .push(push), .pop(pop), .din(din),
    .dout(head), .full(full), .empty(empty), .level(LEVEL)
  );
`ifdef YM_ADDR_CACHE_EN
  logic [YM_AW-1:0] last_addr;
  logic last_ok;
  always_ff @(posedge CLK) begin
    if (RESET) begin
      last_addr <= '0;
      last_ok   <= 1'b0;
    end else if (state == YM_ADDR_PH && cnt == '0) begin
      last_addr <= req.addr;
      last_ok   <= 1'b1;
    end
  end
  assign hit = !head.rd && last_ok && head.addr == last_addr;
`else
  assign hit = 1'b0;
`endif
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= YM_IDLE;
      cnt      <= '0;
      req      <= '0;
      BDIR     <= 1'b0;
      BC       <= 1'b0;
      A8       <= 1'b0;
      DO       <= '0;
      RD_VALID <= 1'b0;
      RD_DATA  <= '0;
    end else begin
      RD_VALID <= 1'b0;
      if (state != YM_IDLE) cnt <= cnt - 1'b1;
      case (state)
        YM_IDLE: if (!empty) begin
          req   <= head;
          BDIR  <= 1'b1;
          A8    <= 1'b1;
          BC    <= !hit;
          DO    <= hit ? head.data : {{(YM_DW-YM_AW){1'b0}}, head.addr};
          cnt   <= HLD;
          state <= hit ? YM_DATA_PH : YM_ADDR_PH;
        end
        YM_ADDR_PH: if (cnt == '0) begin
          state <= YM_ADDR_GAP;
          cnt   <= GP;
          BDIR  <= 1'b0;
          BC    <= 1'b0;
          A8    <= 1'b0;
        end
        YM_ADDR_GAP: if (cnt == '0) begin
          state <= req.rd ? YM_RD_WAIT : YM_DATA_PH;
          cnt   <= HLD;
          BDIR  <= !req.rd;
          A8    <= !req.rd;
          DO    <= req.rd ? DO : req.data;
        end
        YM_DATA_PH: if (cnt == '0) begin
          state <= YM_DATA_GAP;
          cnt   <= GP;
          BDIR  <= 1'b0;
          A8    <= 1'b0;
        end
        YM_DATA_GAP: if (cnt == '0) begin
          state <= YM_IDLE;
          cnt   <= '0;
        end
        YM_RD_WAIT: begin
          RD_DATA  <= DI;
          RD_VALID <= 1'b1;
          state    <= YM_IDLE;
          cnt      <= '0;
        end
        default: state <= YM_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ym_bus_master.sv
// tb_ym_bus_master: directed tests of ym_bus_master against a small ym2149 register model
module tb_ym_bus_master;
  import ym_bus_pkg::*;
`ifdef YM_ADDR_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif
  logic CLK = 1'b0, RESET = 1'b1, REQ_VALID = 1'b0, REQ_RD = 1'b0;
  logic [3:0] REQ_ADDR = '0;
  logic [7:0] REQ_DATA = '0;
  logic [7:0] DI, DO, RD_DATA;
  logic REQ_READY, BDIR, BC, A8, RD_VALID, BUSY;
  logic [3:0] LEVEL;
  int tests = 0, fails = 0;
  logic [7:0] psg [16];
  logic [3:0] active = '0;
  logic prev_bdir = 1'b0;
  int cyc = 0, addr_cyc = 0, wr_cyc = 0, n_addr = 0;
  logic [3:0] log_a [$];
  logic [7:0] log_d [$];

  always #5 CLK = ~CLK;

  ym_bus_master dut (
    .CLK(CLK), .RESET(RESET), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_RD(REQ_RD), .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA), .BDIR(BDIR),
    .BC(BC), .A8(A8), .DO(DO), .DI(DI), .RD_VALID(RD_VALID), .RD_DATA(RD_DATA),
    .BUSY(BUSY), .LEVEL(LEVEL)
  );

  function automatic logic [7:0] msk(input logic [3:0] a);
    case (a)
      4'd1, 4'd3, 4'd5, 4'd13: msk = 8'h0F;
      4'd6, 4'd8, 4'd9, 4'd10: msk = 8'h1F;
      default:                 msk = 8'hFF;
    endcase
  endfunction

  // PSG model: latch on BDIR&BC, write on BDIR&!BC, always drive the selected register
  assign DI = psg[active];
  always @(posedge CLK) cyc++;
  always @(negedge CLK) begin
    if (BDIR && BC) active = DO[3:0];
    if (BDIR && !BC && A8) psg[active] = DO & msk(active);
    if (BDIR && !prev_bdir) begin
      if (BC) begin
        n_addr++;
        addr_cyc = cyc;
      end else begin
        log_a.push_back(active);
        log_d.push_back(DO);
        wr_cyc = cyc;
      end
    end
    prev_bdir = BDIR;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic do_reset;
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic push(input logic rd, input logic [3:0] a, input logic [7:0] d);
    int n = 0;
    REQ_VALID = 1'b1; REQ_RD = rd; REQ_ADDR = a; REQ_DATA = d;
    while (REQ_READY !== 1'b1 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    @(negedge CLK);
    REQ_VALID = 1'b0;
  endtask

  task automatic wait_bdir(input logic bc, output logic ok);
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (BDIR === 1'b1 && BC === bc) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLK);
    end
  endtask

  task automatic wait_idle(output int c, output logic ok);
    ok = 1'b0;
    c = 0;
    for (int n = 0; n < 400; n++) begin
      if (BUSY === 1'b0) begin
        ok = 1'b1;
        c = cyc;
        break;
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_reset;
    do_reset;
    tests++;
    if ({BDIR, BC, A8, DO, RD_VALID, RD_DATA, LEVEL, BUSY, REQ_READY} !== {3'b000, 8'h00, 1'b0, 8'h00, 4'h0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL reset_state: got bdir=%b bc=%b a8=%b do=%h rdv=%b rdd=%h lvl=%0d busy=%b rdy=%b, want all 0 except rdy=1",
               BDIR, BC, A8, DO, RD_VALID, RD_DATA, LEVEL, BUSY, REQ_READY);
    end
  endtask

  task automatic test_single_write;
    logic ok;
    logic [11:0] exp [7] = '{12'hF07, 12'hF07, 12'h807, 12'hD38, 12'hD38, 12'h838, 12'h038};
    push(1'b0, 4'd7, 8'h38);
    wait_bdir(1'b1, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL single_start: no address strobe seen"); end
    for (int i = 0; i < 7; i++) begin
      tests++;
      if ({BUSY, BDIR, BC, A8, DO} !== exp[i]) begin
        fails++;
        $display("FAIL single_wave[%0d]: got busy/bdir/bc/a8/do=%h want %h", i, {BUSY, BDIR, BC, A8, DO}, exp[i]);
      end
      @(negedge CLK);
    end
    tests++;
    if (psg[7] !== 8'h38) begin fails++; $display("FAIL single_reg7: got %h want 38", psg[7]); end
    tests++;
    if (active !== 4'h7) begin fails++; $display("FAIL single_active: got %h want 7", active); end
  endtask

  task automatic test_burst;
    logic ok;
    logic saw_full = 1'b0;
    int c;
    log_a.delete();
    log_d.delete();
    REQ_VALID = 1'b1;
    REQ_RD = 1'b0;
    for (int i = 0; i < 12; i++) begin
      int n = 0;
      REQ_ADDR = i[3:0];
      REQ_DATA = 8'(8'h10 + i);
      while (1) begin
        tests++;
        if (REQ_READY !== (LEVEL != 4'd8)) begin
          fails++;
          $display("FAIL burst_ready: got ready=%b at level=%0d", REQ_READY, LEVEL);
        end
        if (LEVEL === 4'd8) saw_full = 1'b1;
        if (REQ_READY === 1'b1 || n > 200) break;
        @(negedge CLK);
        n++;
      end
      @(negedge CLK);
    end
    REQ_VALID = 1'b0;
    tests++;
    if (saw_full !== 1'b1) begin fails++; $display("FAIL burst_full: level never reached 8"); end
    wait_idle(c, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL burst_idle: BUSY never fell"); end
    tests++;
    if (log_a.size() !== 12) begin fails++; $display("FAIL burst_count: got %0d writes want 12", log_a.size()); end
    tests++;
    if (c - wr_cyc !== 3) begin fails++; $display("FAIL burst_busy_fall: got %0d cycles after last data strobe want 3", c - wr_cyc); end
    for (int i = 0; i < 12 && i < log_a.size(); i++) begin
      tests++;
      if (log_a[i] !== i[3:0] || log_d[i] !== 8'(8'h10 + i)) begin
        fails++;
        $display("FAIL burst_order[%0d]: got reg %0d data %h want reg %0d data %h", i, log_a[i], log_d[i], i, 8'(8'h10 + i));
      end
    end
  endtask

  task automatic test_read;
    logic ok = 1'b0;
    int pulses = 0;
    push(1'b0, 4'd1, 8'hFA);
    push(1'b1, 4'd1, 8'h00);
    for (int n = 0; n < 100; n++) begin
      if (RD_VALID === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    tests++;
    if (!ok) begin fails++; $display("FAIL read_valid: RD_VALID never pulsed"); end
    tests++;
    if (RD_DATA !== 8'h0A) begin fails++; $display("FAIL read_data: got %h want 0a", RD_DATA); end
    tests++;
    if (cyc - addr_cyc !== 4) begin fails++; $display("FAIL read_latency: got %0d want 4", cyc - addr_cyc); end
    for (int n = 0; n < 10; n++) begin
      @(negedge CLK);
      if (RD_VALID === 1'b1) pulses++;
    end
    tests++;
    if (pulses !== 0) begin fails++; $display("FAIL read_pulse: got %0d extra pulses want 0", pulses); end
  endtask

  task automatic test_cache;
    logic ok;
    int t0, t1;
    do_reset;
    n_addr = 0;
    log_a.delete();
    log_d.delete();
    push(1'b0, 4'd8, 8'h05);
    push(1'b0, 4'd8, 8'h0F);
    wait_bdir(1'b1, ok);
    t0 = cyc;
    wait_idle(t1, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL cache_idle: BUSY never fell"); end
    tests++;
    if (n_addr !== (CACHE ? 1 : 2)) begin fails++; $display("FAIL cache_addr_strobes: got %0d want %0d", n_addr, CACHE ? 1 : 2); end
    tests++;
    if (t1 - t0 !== (CACHE ? 10 : 13)) begin fails++; $display("FAIL cache_span: got %0d want %0d", t1 - t0, CACHE ? 10 : 13); end
    tests++;
    if (log_d.size() !== 2 || log_d[0] !== 8'h05 || log_d[1] !== 8'h0F) begin
      fails++;
      $display("FAIL cache_data: got %0d writes, first %h second %h want 05 0f", log_d.size(), log_d[0], log_d[1]);
    end
    tests++;
    if (psg[8] !== 8'h0F) begin fails++; $display("FAIL cache_reg8: got %h want 0f", psg[8]); end
  endtask

  task automatic test_reset_mid;
    logic ok;
    int c;
    do_reset;
    push(1'b0, 4'd3, 8'h0C);
    push(1'b0, 4'd5, 8'h0A);
    wait_bdir(1'b0, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL mid_data_phase: no data strobe seen"); end
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    tests++;
    if ({BDIR, LEVEL, REQ_READY, RD_VALID} !== {1'b0, 4'd0, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL mid_reset: got bdir=%b level=%0d ready=%b rdv=%b want 0 0 1 0", BDIR, LEVEL, REQ_READY, RD_VALID);
    end
    RESET = 1'b0;
    @(negedge CLK);
    n_addr = 0;
    log_a.delete();
    log_d.delete();
    push(1'b0, 4'd3, 8'h05);
    wait_idle(c, ok);
    repeat (3) @(negedge CLK);
    tests++;
    if (n_addr !== 1) begin fails++; $display("FAIL mid_addr_phase: got %0d address strobes want 1", n_addr); end
    tests++;
    if (log_a.size() !== 1 || log_a[0] !== 4'd3 || log_d[0] !== 8'h05) begin
      fails++;
      $display("FAIL mid_after: got %0d writes, first reg %0d data %h want 1 write reg 3 data 05", log_a.size(), log_a[0], log_d[0]);
    end
    tests++;
    if (psg[3] !== 8'h05) begin fails++; $display("FAIL mid_reg3: got %h want 05", psg[3]); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) psg[i] = 8'h00;
    @(negedge CLK);
    test_reset;
    test_single_write;
    test_burst;
    test_read;
    test_cache;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
